combo_sequencer: RTL and testbench

- Combination-lock controller for the safebox vault.
- Consumes the 5-bit dial position (vault_code) and the decoded dial direction (direction: 1 = clockwise, 0 = anticlockwise).
- Sequences a three-number combination with alternating approach directions, counts failed attempts, and enforces a timed lockout.
- Drives the unlock signal for the door actuator and the alarm indicator.

---
 rtl/combo_sequencer.sv | 164 ++++++++++++++++
 tb/tb_combo_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/combo_sequencer.sv
// Three-number combination lock with dwell-based entry detection, failed-attempt
// counting and a timed lockout. Outputs are registered copies of the next state.
module combo_sequencer #(
  parameter logic [4:0] CODE0          = 5'd5,
  parameter logic [4:0] CODE1          = 5'd20,
  parameter logic [4:0] CODE2          = 5'd11,
  parameter int         DWELL          = 4,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] vault_code,
  input  logic       direction,
  input  logic       lock_req,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] stage,
  output logic [2:0] fail_count
);

  localparam logic [3:0]  DWELL_L     = 4'(DWELL);
  localparam logic [2:0]  MAX_FAILS_L = 3'(MAX_FAILS);
  localparam logic [15:0] LOCK_LOAD   = 16'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_S0,
    ST_S1,
    ST_S2,
    ST_OPEN,
    ST_LOCKOUT
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  prev_code_q, prev_code_d;
  logic        prev_valid_q, prev_valid_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  fail_q, fail_d;
  logic        unlocked_q, unlocked_d;
  logic        alarm_q, alarm_d;
  logic [1:0]  stage_q, stage_d;

  logic entry;
  logic fail_event;

  // Dwell tracking: an entry fires only on the edge the counter first reaches DWELL.
  always_comb begin
    prev_code_d  = vault_code;
    prev_valid_d = 1'b1;
    if (!prev_valid_q || (vault_code != prev_code_q)) begin
      hold_cnt_d = 4'd1;
    end else if (hold_cnt_q < DWELL_L) begin
      hold_cnt_d = hold_cnt_q + 4'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
    entry = (hold_cnt_d == DWELL_L) && (hold_cnt_q != DWELL_L);
  end

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    fail_event = 1'b0;

    case (state_q)
      ST_S0: begin
        // Wrong entries in S0 are free so the user can spin the dial.
        if (entry && (vault_code == CODE0) && direction) begin
          state_d = ST_S1;
        end
      end
      ST_S1: begin
        if (entry) begin
          if ((vault_code == CODE1) && !direction) begin
            state_d = ST_S2;
          end else begin
            fail_event = 1'b1;
          end
        end
      end
      ST_S2: begin
        if (entry) begin
          if ((vault_code == CODE2) && direction) begin
            state_d = ST_OPEN;
            fail_d  = 3'd0;
          end else begin
            fail_event = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (lock_req) begin
          state_d = ST_S0;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == 16'd0) begin
          state_d = ST_S0;
          fail_d  = 3'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_S0;
      end
    endcase

    if (fail_event) begin
      if ((fail_q + 3'd1) == MAX_FAILS_L) begin
        state_d = ST_LOCKOUT;
        timer_d = LOCK_LOAD;
        fail_d  = MAX_FAILS_L;
      end else begin
        state_d = ST_S0;
        fail_d  = fail_q + 3'd1;
      end
    end
  end

  // Outputs are registered from the next state so they never glitch.
  always_comb begin
    unlocked_d = (state_d == ST_OPEN);
    alarm_d    = (state_d == ST_LOCKOUT);
    case (state_d)
      ST_S0:   stage_d = 2'd0;
      ST_S1:   stage_d = 2'd1;
      ST_S2:   stage_d = 2'd2;
      default: stage_d = 2'd3;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_S0;
      prev_code_q  <= 5'd0;
      prev_valid_q <= 1'b0;
      hold_cnt_q   <= 4'd0;
      timer_q      <= 16'd0;
      fail_q       <= 3'd0;
      unlocked_q   <= 1'b0;
      alarm_q      <= 1'b0;
      stage_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      prev_code_q  <= prev_code_d;
      prev_valid_q <= prev_valid_d;
      hold_cnt_q   <= hold_cnt_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      unlocked_q   <= unlocked_d;
      alarm_q      <= alarm_d;
      stage_q      <= stage_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign alarm      = alarm_q;
  assign stage      = stage_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_combo_sequencer.sv
// Directed bench for combo_sequencer: each task drives one scenario and checks
// the registered outputs one time unit after the rising edge.
module tb_combo_sequencer;

  logic       clock;
  logic       reset;
  logic [4:0] vault_code;
  logic       direction;
  logic       lock_req;
  logic       unlocked;
  logic       alarm;
  logic [1:0] stage;
  logic [2:0] fail_count;

  int checks;
  int errors;

  combo_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .vault_code (vault_code),
    .direction  (direction),
    .lock_req   (lock_req),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .stage      (stage),
    .fail_count (fail_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic [4:0] code, input logic dir, input int n);
    vault_code = code;
    direction  = dir;
    repeat (n) tick();
  endtask

  task automatic expect_outs(input string name, input logic [1:0] exp_stage,
                             input logic [2:0] exp_fail, input logic exp_unl,
                             input logic exp_alarm);
    checks++;
    if ({stage, fail_count, unlocked, alarm} !== {exp_stage, exp_fail, exp_unl, exp_alarm}) begin
      errors++;
      $display("FAIL %s: stage=%0d fail=%0d unlocked=%0b alarm=%0b, required stage=%0d fail=%0d unlocked=%0b alarm=%0b",
               name, stage, fail_count, unlocked, alarm, exp_stage, exp_fail, exp_unl, exp_alarm);
    end else begin
      $display("ok   %s: stage=%0d fail=%0d unlocked=%0b alarm=%0b",
               name, stage, fail_count, unlocked, alarm);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    expect_outs("reset_state", 2'd0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_correct_sequence();
    hold(5'd0, 1'b1, 1);
    hold(5'd5, 1'b1, 4);
    expect_outs("seq_code0", 2'd1, 3'd0, 1'b0, 1'b0);
    hold(5'd20, 1'b0, 4);
    expect_outs("seq_code1", 2'd2, 3'd0, 1'b0, 1'b0);
    hold(5'd11, 1'b1, 4);
    expect_outs("seq_open", 2'd3, 3'd0, 1'b1, 1'b0);
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    expect_outs("seq_relock", 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_dwell_boundary();
    hold(5'd5, 1'b1, 3);
    expect_outs("dwell_3_edges", 2'd0, 3'd0, 1'b0, 1'b0);
    hold(5'd6, 1'b1, 1);
    expect_outs("dwell_broken", 2'd0, 3'd0, 1'b0, 1'b0);
    hold(5'd5, 1'b1, 3);
    expect_outs("dwell_edge3", 2'd0, 3'd0, 1'b0, 1'b0);
    tick();
    expect_outs("dwell_edge4", 2'd1, 3'd0, 1'b0, 1'b0);
    // A re-fire of CODE0 while in S1 would be a fail.
    hold(5'd5, 1'b1, 6);
    expect_outs("dwell_single_entry", 2'd1, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wrong_direction();
    hold(5'd20, 1'b1, 4);
    expect_outs("wrong_dir", 2'd0, 3'd1, 1'b0, 1'b0);
  endtask

  task automatic test_lockout();
    logic [4:0] codes [4];
    logic       dirs  [4];
    codes[0] = 5'd5;  dirs[0] = 1'b1;
    codes[1] = 5'd20; dirs[1] = 1'b0;
    codes[2] = 5'd11; dirs[2] = 1'b1;
    codes[3] = 5'd11; dirs[3] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int f = 1; f <= 2; f++) begin
      hold(5'd5, 1'b1, 4);
      hold(5'd19, 1'b1, 4);
      expect_outs($sformatf("lock_fail%0d", f), 2'd0, 3'(f), 1'b0, 1'b0);
    end
    hold(5'd5, 1'b1, 4);
    hold(5'd19, 1'b1, 4);
    expect_outs("lock_enter", 2'd3, 3'd3, 1'b0, 1'b1);
    // Cycle 1 of alarm already seen; cycles 2..16 while dialling the code.
    for (int i = 1; i <= 15; i++) begin
      vault_code = codes[(i - 1) / 4];
      direction  = dirs[(i - 1) / 4];
      tick();
      expect_outs($sformatf("lock_cycle%0d", i + 1), 2'd3, 3'd3, 1'b0, 1'b1);
    end
    tick();
    expect_outs("lock_exit", 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_s0_tolerance();
    hold(5'd3, 1'b0, 4);
    expect_outs("s0_code3", 2'd0, 3'd0, 1'b0, 1'b0);
    hold(5'd7, 1'b1, 4);
    expect_outs("s0_code7", 2'd0, 3'd0, 1'b0, 1'b0);
    hold(5'd30, 1'b0, 4);
    expect_outs("s0_code30", 2'd0, 3'd0, 1'b0, 1'b0);
    hold(5'd20, 1'b0, 4);
    expect_outs("s0_code20", 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    hold(5'd5, 1'b1, 4);
    hold(5'd19, 1'b1, 4);
    hold(5'd5, 1'b1, 4);
    hold(5'd19, 1'b1, 4);
    hold(5'd5, 1'b1, 4);
    hold(5'd20, 1'b0, 4);
    expect_outs("mid_in_s2", 2'd2, 3'd2, 1'b0, 1'b0);
    vault_code = 5'd5;
    direction  = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_outs("mid_reset_s2", 2'd0, 3'd0, 1'b0, 1'b0);
    hold(5'd5, 1'b1, 3);
    expect_outs("mid_restart_3", 2'd0, 3'd0, 1'b0, 1'b0);
    tick();
    expect_outs("mid_restart_4", 2'd1, 3'd0, 1'b0, 1'b0);
    hold(5'd19, 1'b1, 4);
    hold(5'd5, 1'b1, 4);
    hold(5'd19, 1'b1, 4);
    hold(5'd5, 1'b1, 4);
    hold(5'd19, 1'b1, 4);
    expect_outs("mid_lockout", 2'd3, 3'd3, 1'b0, 1'b1);
    hold(5'd19, 1'b1, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_outs("mid_reset_lock", 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    hold(5'd5, 1'b1, 4);
    hold(5'd20, 1'b0, 4);
    hold(5'd11, 1'b1, 4);
    expect_outs("b2b_open", 2'd3, 3'd0, 1'b1, 1'b0);
    hold(5'd5, 1'b1, 4);
    expect_outs("b2b_open_ignore", 2'd3, 3'd0, 1'b1, 1'b0);
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    expect_outs("b2b_relock", 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    vault_code = 5'd0;
    direction  = 1'b0;
    lock_req   = 1'b0;
    test_reset();
    test_correct_sequence();
    test_dwell_boundary();
    test_wrong_direction();
    test_lockout();
    test_s0_tolerance();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
